// File: rtl/serial_reciprocal_unit.sv
// Serial-in / serial-out fixed-point reciprocal: loads a Qm.n operand in NIB-bit chunks,
// divides 2^(2*FRAC_BITS) by |x| one quotient bit per clock, saturates, streams result out.
module serial_reciprocal_unit #(
   parameter int INT_BITS  = 6,
   parameter int FRAC_BITS = 10,
   parameter int NIB       = 4,
   parameter int OUT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [NIB-1:0]   i_data,
   input  logic             i_abs,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [OUT_W-1:0] o_data,
   output logic             o_last,
   output logic             o_sat,
   output logic             busy
);

   localparam int W    = INT_BITS + FRAC_BITS;
   localparam int QW   = 2 * FRAC_BITS + 1;
   localparam int NIN  = W / NIB;
   localparam int NOUT = W / OUT_W;
   localparam int LCW  = $clog2(NIN + 1);
   localparam int DCW  = $clog2(QW + 1);
   localparam int OCW  = $clog2(NOUT + 1);

   localparam logic [QW-1:0] Q_MAX_POS = QW'((2 ** (W - 1)) - 1);
   localparam logic [QW-1:0] Q_MAX_NEG = QW'(2 ** (W - 1));
   localparam logic [W-1:0]  RES_MAX_POS = {1'b0, {(W - 1){1'b1}}};
   localparam logic [W-1:0]  RES_MIN_NEG = {1'b1, {(W - 1){1'b0}}};

   typedef enum logic [1:0] {LOAD, DIV, FIX, OUT} state_t;

   state_t          state;
   logic [W-1:0]    operand;
   logic            abs_q;
   logic [W-1:0]    rem;
   logic [QW-1:0]   quo;
   logic [W-1:0]    res_sh;
   logic [LCW-1:0]  ld_cnt;
   logic [DCW-1:0]  div_cnt;
   logic [OCW-1:0]  out_cnt;

   logic [W-1:0]    mag;
   logic [W:0]      rem_sh;
   logic            rem_ge;
   logic            neg;
   logic [W-1:0]    q_lo;
   logic [W-1:0]    fix_res;
   logic            fix_sat;

   // The dividend is a single 1 at bit 2*FRAC_BITS, so only the first iteration shifts in a 1.
   always_comb begin
      mag     = operand[W-1] ? (~operand + W'(1)) : operand;
      rem_sh  = {rem, (div_cnt == '0)};
      rem_ge  = (rem_sh >= {1'b0, mag});
      neg     = operand[W-1] & ~abs_q;
      q_lo    = W'(quo);
      fix_res = neg ? (~q_lo + W'(1)) : q_lo;
      fix_sat = 1'b0;
      if (mag == '0) begin
         fix_res = RES_MAX_POS;
         fix_sat = 1'b1;
      end else if (!neg && quo > Q_MAX_POS) begin
         fix_res = RES_MAX_POS;
         fix_sat = 1'b1;
      end else if (neg && quo > Q_MAX_NEG) begin
         fix_res = RES_MIN_NEG;
         fix_sat = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= LOAD;
         operand <= '0;
         abs_q   <= 1'b0;
         rem     <= '0;
         quo     <= '0;
         res_sh  <= '0;
         ld_cnt  <= '0;
         div_cnt <= '0;
         out_cnt <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_last  <= 1'b0;
         o_sat   <= 1'b0;
         busy    <= 1'b0;
         i_ready <= 1'b1;
      end else begin
         case (state)
            LOAD: begin
               if (i_valid) begin
                  operand <= {operand[W-NIB-1:0], i_data};
                  if (ld_cnt == LCW'(NIN - 1)) begin
                     ld_cnt  <= '0;
                     abs_q   <= i_abs;
                     rem     <= '0;
                     quo     <= '0;
                     div_cnt <= '0;
                     i_ready <= 1'b0;
                     busy    <= 1'b1;
                     state   <= DIV;
                  end else begin
                     ld_cnt <= ld_cnt + LCW'(1);
                  end
               end
            end
            DIV: begin
               rem <= rem_ge ? W'(rem_sh - {1'b0, mag}) : W'(rem_sh);
               quo <= {quo[QW-2:0], rem_ge};
               if (div_cnt == DCW'(QW - 1)) begin
                  div_cnt <= '0;
                  state   <= FIX;
               end else begin
                  div_cnt <= div_cnt + DCW'(1);
               end
            end
            FIX: begin
               o_data  <= fix_res[W-1 -: OUT_W];
               res_sh  <= fix_res << OUT_W;
               o_sat   <= fix_sat;
               o_valid <= 1'b1;
               o_last  <= (NOUT == 1);
               out_cnt <= '0;
               state   <= OUT;
            end
            OUT: begin
               if (o_ready) begin
                  if (o_last) begin
                     o_valid <= 1'b0;
                     o_data  <= '0;
                     o_last  <= 1'b0;
                     o_sat   <= 1'b0;
                     out_cnt <= '0;
                     busy    <= 1'b0;
                     i_ready <= 1'b1;
                     state   <= LOAD;
                  end else begin
                     o_data  <= res_sh[W-1 -: OUT_W];
                     res_sh  <= res_sh << OUT_W;
                     out_cnt <= out_cnt + OCW'(1);
                     o_last  <= (out_cnt == OCW'(NOUT - 2));
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_reciprocal_unit.sv
// Bench for serial_reciprocal_unit: table-driven vectors plus reset/stall corner sequences,
// with expected output chunks queued on load and compared as the DUT streams them out.
module tb_serial_reciprocal_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       i_valid = 1'b0;
   logic       i_ready;
   logic [3:0] i_data = '0;
   logic       i_abs = 1'b0;
   logic       o_valid;
   logic       o_ready = 1'b0;
   logic [7:0] o_data;
   logic       o_last;
   logic       o_sat;
   logic       busy;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [15:0] x;
      logic        abs_mode;
      int          gap;
      int          stall;
      logic [15:0] exp_res;
      logic        exp_sat;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       last;
      logic       sat;
   } chunk_t;

   vec_t   vecs[10];
   chunk_t sb[$];

   serial_reciprocal_unit dut (
      .clk(clk), .reset(reset),
      .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_abs(i_abs),
      .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last),
      .o_sat(o_sat), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: integer division on the signed operand, then clamp to the Q6.10 range.
   function automatic logic [16:0] model(input logic [15:0] x, input logic a);
      longint xv;
      longint m;
      longint q;
      longint t;
      logic   neg;
      xv  = longint'($signed(x));
      m   = (xv < 0) ? -xv : xv;
      neg = x[15] && !a;
      if (m == 0) return {1'b1, 16'h7FFF};
      q = (longint'(1) << 20) / m;
      if (!neg) begin
         if (q > 32767) return {1'b1, 16'h7FFF};
         return {1'b0, q[15:0]};
      end
      if (q > 32768) return {1'b1, 16'h8000};
      t = -q;
      return {1'b0, t[15:0]};
   endfunction

   task automatic applyStimulus(input logic [15:0] x, input logic a, input int gap,
                                input logic [15:0] res, input logic sat);
      chunk_t c;
      c = '{res[15:8], 1'b0, sat};
      sb.push_back(c);
      c = '{res[7:0], 1'b1, sat};
      sb.push_back(c);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         compare("i_ready_in_load", {31'b0, i_ready}, 32'd1);
         i_valid = 1'b1;
         i_data  = x[15-4*i -: 4];
         i_abs   = a;
         @(posedge clk);
         if (gap > 0 && i < 3) begin
            @(negedge clk);
            i_valid = 1'b0;
            i_abs   = ~a;
            repeat (gap - 1) @(negedge clk);
         end
      end
      #1 i_valid = 1'b0;
      i_abs = ~a;
   endtask

   task automatic checkOutput(input int stall);
      chunk_t e;
      int     waitc;
      for (int k = 0; k < 2; k++) begin
         waitc = 0;
         @(negedge clk);
         while (!o_valid && waitc < 200) begin
            @(negedge clk);
            waitc++;
         end
         if (!o_valid || sb.size() == 0) begin
            compare("o_valid_timeout", {31'b0, o_valid}, 32'd1);
            sb.delete();
            return;
         end
         e = sb.pop_front();
         compare("o_data", {24'b0, o_data}, {24'b0, e.data});
         compare("o_last", {31'b0, o_last}, {31'b0, e.last});
         compare("o_sat", {31'b0, o_sat}, {31'b0, e.sat});
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            compare("stall_o_data", {24'b0, o_data}, {24'b0, e.data});
            compare("stall_o_last", {31'b0, o_last}, {31'b0, e.last});
         end
         o_ready = 1'b1;
         @(posedge clk);
         #1 o_ready = 1'b0;
      end
      @(negedge clk);
      compare("o_valid_after_burst", {31'b0, o_valid}, 32'd0);
      compare("i_ready_after_burst", {31'b0, i_ready}, 32'd1);
      compare("o_sat_after_burst", {31'b0, o_sat}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [16:0] mr;
      logic [15:0] rx;
      logic        ra;
      int          n;
      int          w;

      vecs[0] = '{16'h0400, 1'b0, 0, 0, 16'h0400, 1'b0};
      vecs[1] = '{16'h0C00, 1'b0, 2, 0, 16'h0155, 1'b0};
      vecs[2] = '{16'h0200, 1'b0, 0, 5, 16'h0800, 1'b0};
      vecs[3] = '{16'hF800, 1'b0, 0, 0, 16'hFE00, 1'b0};
      vecs[4] = '{16'hF800, 1'b1, 0, 0, 16'h0200, 1'b0};
      vecs[5] = '{16'h0000, 1'b0, 0, 0, 16'h7FFF, 1'b1};
      vecs[6] = '{16'h0001, 1'b0, 0, 0, 16'h7FFF, 1'b1};
      vecs[7] = '{16'hFFFF, 1'b0, 3, 0, 16'h8000, 1'b1};
      vecs[8] = '{16'h8000, 1'b1, 0, 0, 16'h0020, 1'b0};
      vecs[9] = '{16'h8000, 1'b0, 0, 0, 16'hFFE0, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      compare("reset_outputs", {26'b0, o_valid, o_data, o_last, o_sat, busy, i_ready},
              {26'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].x, vecs[i].abs_mode, vecs[i].gap, vecs[i].exp_res, vecs[i].exp_sat);
         if (i == 0) begin
            n = 0;
            do begin
               @(posedge clk);
               n++;
               #1;
               if (n == 1) compare("busy_in_div", {30'b0, busy, i_ready}, 32'd2);
            end while (!o_valid && n < 100);
            compare("latency", n, 32'd22);
         end
         checkOutput(vecs[i].stall);
      end

      for (int r = 0; r < 6; r++) begin
         rx = 16'($urandom_range(0, 65535));
         ra = 1'($urandom_range(0, 1));
         mr = model(rx, ra);
         applyStimulus(rx, ra, 0, mr[15:0], mr[16]);
         checkOutput(0);
      end

      // Reset in the middle of the division discards it.
      applyStimulus(16'h0C00, 1'b0, 0, 16'h0155, 1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      compare("reset_mid_div", {26'b0, o_valid, o_data, o_last, o_sat, busy, i_ready},
              {26'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
      @(negedge clk);
      reset = 1'b0;
      sb.delete();

      // Reset while a saturated burst is on the output.
      applyStimulus(16'h0000, 1'b0, 0, 16'h7FFF, 1'b1);
      w = 0;
      while (!o_valid && w < 100) begin
         @(negedge clk);
         w++;
      end
      compare("reach_out_before_reset", {30'b0, o_valid, o_sat}, 32'd3);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      compare("reset_mid_out", {26'b0, o_valid, o_data, o_last, o_sat, busy, i_ready},
              {26'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
      @(negedge clk);
      reset = 1'b0;
      sb.delete();

      applyStimulus(16'h0800, 1'b0, 0, 16'h0200, 1'b0);
      checkOutput(0);

      compare("scoreboard_empty", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_reciprocal_unit.md
Name: serial_reciprocal_unit

Overview:
Parametrised, handshaked successor to the tracer's nibble-serial reciprocal stage. It loads a signed fixed-point operand serially in NIB-bit chunks and computes its reciprocal with an iterative restoring divider, one quotient bit per clock, instead of a combinational array. It applies optional absolute-value mode and saturation, then streams the result out in OUT_W-bit chunks, MSB first. It sits between the host-facing serial pins and the ray-casting datapath, which needs 1/x for ray-direction deltas.

Parameters:
INT_BITS, 6, integer bits of the Qm.n operand and result, sign bit included.
FRAC_BITS, 10, fractional bits. W = INT_BITS + FRAC_BITS.
NIB, 4, input chunk width. W must be a multiple of NIB.
OUT_W, 8, output chunk width. W must be a multiple of OUT_W.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  reset, synchronous, active-high.
i_valid  in  1  input chunk valid.
i_ready  out  1  high in LOAD state only.
i_data  in  NIB  operand chunk, MSB chunk first.
i_abs  in  1  sampled with the final input chunk; 1 means the result is the reciprocal of |x|.
o_valid  out  1  output chunk valid.
o_ready  in  1  consumer accepts the chunk.
o_data  out  OUT_W  result chunk, MSB chunk first.
o_last  out  1  high with the final output chunk.
o_sat  out  1  result saturated or x==0; held for the whole output burst.
busy  out  1  high in any state except LOAD.

Behaviour:
- States: LOAD -> DIV -> FIX -> OUT -> LOAD.
- Reset, including mid-operation, forces:
  - state LOAD, all counters 0, operand/remainder/quotient 0;
  - o_valid=0, o_data=0, o_last=0, o_sat=0, busy=0, i_ready=1.
  - Any partial load, division or output burst is discarded.
- LOAD:
  - On i_valid && i_ready: operand <= {operand[W-NIB-1:0], i_data}; chunk count increments.
  - After W/NIB accepts, go to DIV on the same edge. i_abs is captured on that edge.
  - i_valid low holds state; there is no timeout.
- DIV:
  - Magnitude m = |x| as W-bit unsigned, so x = -2^(W-1) gives m = 2^(W-1).
  - Dividend D = 2^(2*FRAC_BITS).
  - Restoring division runs 2*FRAC_BITS+1 iterations, one per clock, producing a (2*FRAC_BITS+1)-bit quotient q = floor(D/m).
  - If m == 0, iterations still run; the result is forced in FIX.
- FIX (1 clock): neg = x[W-1] && !i_abs.
  - m==0: result 2^(W-1)-1, sat=1.
  - !neg and q > 2^(W-1)-1: result 2^(W-1)-1, sat=1.
  - neg and q > 2^(W-1): result -2^(W-1), sat=1.
  - Otherwise: result q (if !neg) or -q (if neg), truncated toward zero; sat=0.
- Latency: o_valid first goes high 2*FRAC_BITS+2 clocks after the edge accepting the final input chunk (22 at defaults).
- OUT:
  - o_valid=1; o_data = result chunk k, MSB first.
  - Chunk k advances only on o_valid && o_ready. o_data is stable while o_ready is low.
  - o_last=1 on chunk W/OUT_W-1. Its acceptance returns to LOAD with o_valid=0 and o_sat=0 on that edge.
  - Back-to-back: a new operand may be loaded from the next cycle.
- Inputs are ignored outside LOAD (i_ready=0). o_ready is ignored outside OUT.

Test Plan:
- Load 0x0400 (1.0) as nibbles 0,4,0,0 with i_abs=0 -> o_valid exactly 22 clocks after the last accept; o_data 0x04 then 0x00 with o_last; o_sat=0.
- Load 0x0C00 (3.0) -> 0x01, 0x55 (341); load 0x0200 (0.5) -> 0x08, 0x00.
- Load 0xF800 (-2.0): i_abs=0 -> 0xFE, 0x00; i_abs=1 -> 0x02, 0x00; o_sat=0 in both.
- Load 0x0000 -> 0x7F, 0xFF with o_sat=1. Load 0x0001 -> 0x7F, 0xFF with o_sat=1. Load 0xFFFF with i_abs=0 -> 0x80, 0x00 with o_sat=1.
- Hold o_ready low 5 clocks in OUT -> o_data/o_last stable, no chunk skipped. Drop i_valid between nibbles -> load pauses, result unchanged.
- Assert reset mid-DIV, then mid-OUT -> next cycle all outputs 0, i_ready=1. A fresh load of 0x0800 -> 0x02, 0x00.
